// File: rtl/led_pattern_monitor_pkg.sv
// Shared definitions for the LED pattern generator and its monitor.
// Holds the pattern mode codes, the default step periods per frequency
// code, the period tolerance, the monitor lock-FSM state encoding and
// small one-hot helpers used by the monitor.
package led_pattern_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL = 2'd0,
    MODE_ROTR = 2'd1,
    MODE_CNT  = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // not armed: waiting for the first step
    S_ARM    = 2'd1,  // armed, masks fresh, nothing accumulated yet
    S_TRACK  = 2'd2,  // accumulating consistent steps
    S_LOCKED = 2'd3   // mode/freq inferred and being policed
  } lock_state_e;

  localparam int unsigned P0_DEF     = 1024;
  localparam int unsigned P1_DEF     = 256;
  localparam int unsigned P2_DEF     = 64;
  localparam int unsigned P3_DEF     = 16;
  localparam int unsigned TOL_DEF    = 2;
  localparam int unsigned LOCK_N_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 12;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] onehot_idx4(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/led_step_classifier.sv
// Purely combinational classifier for one bus step.
// Ports:
//   old_i    [7:0]     bus value before the step
//   new_i    [7:0]     bus value after the step
//   period_i [CNT_W:0] clocks since the previous step
//   mvec_o   [3:0]     modes consistent with old->new (rotl, rotr, +1, invert)
//   fvec_o   [3:0]     freq codes whose period is within +/-TOL of period_i
module led_step_classifier #(
  parameter int unsigned P0    = 1024,
  parameter int unsigned P1    = 256,
  parameter int unsigned P2    = 64,
  parameter int unsigned P3    = 16,
  parameter int unsigned TOL   = 2,
  parameter int unsigned CNT_W = 12
) (
  input  logic [7:0]     old_i,
  input  logic [7:0]     new_i,
  input  logic [CNT_W:0] period_i,
  output logic [3:0]     mvec_o,
  output logic [3:0]     fvec_o
);

  localparam logic [CNT_W:0] PK0   = (CNT_W + 1)'(P0);
  localparam logic [CNT_W:0] PK1   = (CNT_W + 1)'(P1);
  localparam logic [CNT_W:0] PK2   = (CNT_W + 1)'(P2);
  localparam logic [CNT_W:0] PK3   = (CNT_W + 1)'(P3);
  localparam logic [CNT_W:0] TOL_W = (CNT_W + 1)'(TOL);

  // Absolute difference taken in the wider width so no wrap can occur.
  function automatic logic in_tol(input logic [CNT_W:0] per, input logic [CNT_W:0] pk);
    logic [CNT_W:0] diff;
    if (per >= pk) begin
      diff = per - pk;
    end else begin
      diff = pk - per;
    end
    return (diff <= TOL_W);
  endfunction

  // Mode and frequency match vectors for the current step.
  always_comb begin
    mvec_o[0] = (new_i == {old_i[6:0], old_i[7]});
    mvec_o[1] = (new_i == {old_i[0], old_i[7:1]});
    mvec_o[2] = (new_i == (old_i + 8'd1));
    mvec_o[3] = ((new_i ^ old_i) == 8'hFF);
    fvec_o[0] = in_tol(period_i, PK0);
    fvec_o[1] = in_tol(period_i, PK1);
    fvec_o[2] = in_tol(period_i, PK2);
    fvec_o[3] = in_tol(period_i, PK3);
  end

endmodule

// File: rtl/led_pattern_monitor.sv
// Passive monitor for the 8-bit LED pattern bus. Infers the generator's
// mode and step-rate code, raises locked once the inference is stable and
// pulses err on a mismatch or stall while locked.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   led_in   [7:0] pattern bus, synchronous to clk
//   mode_out [1:0] inferred mode (rotl, rotr, up-count, invert)
//   freq_out [1:0] inferred freq code
//   locked   mode_out/freq_out valid
//   err      one-cycle pulse on mismatch or stall while locked
//   err_cnt  [7:0] saturating err pulse count (only with ERR_CNT_EN)
// Build option: define ERR_CNT_EN to add the err_cnt port and counter.
module led_pattern_monitor
  import led_pattern_monitor_pkg::*;
#(
  parameter int unsigned P0     = P0_DEF,
  parameter int unsigned P1     = P1_DEF,
  parameter int unsigned P2     = P2_DEF,
  parameter int unsigned P3     = P3_DEF,
  parameter int unsigned TOL    = TOL_DEF,
  parameter int unsigned LOCK_N = LOCK_N_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] led_in,
  output logic [1:0] mode_out,
  output logic [1:0] freq_out,
  output logic       locked,
  output logic       err
`ifdef ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned    SW        = $clog2(LOCK_N + 1);
  localparam logic [SW-1:0]  LOCK_N_W  = SW'(LOCK_N);
  // A stall is declared as cnt rolls past P0+TOL, so any in-tolerance
  // period still ends in a normal step.
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(P0 + TOL);

  lock_state_e      state_q, state_d;
  logic [7:0]       led_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mode_mask_q, mode_mask_d;
  logic [3:0]       freq_mask_q, freq_mask_d;
  logic [SW-1:0]    streak_q, streak_d;
  mode_e            mode_q, mode_d;
  logic [1:0]       freq_q, freq_d;
  logic             err_q, err_d;

  logic             step_s, stall_s;
  logic [CNT_W:0]   period_s;
  logic [3:0]       mvec_s, fvec_s, mm_s, fm_s;
  logic [SW-1:0]    streak_inc_s;

  assign step_s       = (led_in != led_q);
  assign period_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign stall_s      = (state_q != S_IDLE) && !step_s && (cnt_q >= STALL_LIM);
  assign mm_s         = mode_mask_q & mvec_s;
  assign fm_s         = freq_mask_q & fvec_s;
  assign streak_inc_s = (streak_q >= LOCK_N_W) ? streak_q : (streak_q + SW'(1));

  led_step_classifier #(
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .TOL(TOL), .CNT_W(CNT_W)
  ) u_cls (
    .old_i    (led_q),
    .new_i    (led_in),
    .period_i (period_s),
    .mvec_o   (mvec_s),
    .fvec_o   (fvec_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      led_q       <= 8'h00;
      cnt_q       <= '0;
      mode_mask_q <= 4'hF;
      freq_mask_q <= 4'hF;
      streak_q    <= '0;
      mode_q      <= MODE_ROTL;
      freq_q      <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_in;
      cnt_q       <= cnt_d;
      mode_mask_q <= mode_mask_d;
      freq_mask_q <= freq_mask_d;
      streak_q    <= streak_d;
      mode_q      <= mode_d;
      freq_q      <= freq_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic for the lock FSM, masks and period counter.
  always_comb begin
    state_d     = state_q;
    mode_mask_d = mode_mask_q;
    freq_mask_d = freq_mask_q;
    streak_d    = streak_q;
    mode_d      = mode_q;
    freq_d      = freq_q;
    err_d       = 1'b0;
    if (step_s) begin
      cnt_d = '0;
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (step_s) begin
          state_d     = S_ARM;
          mode_mask_d = 4'hF;
          freq_mask_d = 4'hF;
          streak_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM, S_TRACK: begin
        if (stall_s) begin
          state_d     = S_IDLE;
          mode_mask_d = 4'hF;
          freq_mask_d = 4'hF;
          streak_d    = '0;
        end else if (step_s) begin
          if ((mm_s == 4'h0) || (fm_s == 4'h0)) begin
            // Inconsistent step: it becomes the new arming step.
            state_d     = S_ARM;
            mode_mask_d = 4'hF;
            freq_mask_d = 4'hF;
            streak_d    = '0;
          end else begin
            mode_mask_d = mm_s;
            freq_mask_d = fm_s;
            streak_d    = streak_inc_s;
            if ((streak_inc_s >= LOCK_N_W) && is_onehot4(mm_s) && is_onehot4(fm_s)) begin
              state_d = S_LOCKED;
              mode_d  = mode_e'(onehot_idx4(mm_s));
              freq_d  = onehot_idx4(fm_s);
            end else begin
              state_d = S_TRACK;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOCKED: begin
        if (stall_s) begin
          state_d     = S_IDLE;
          err_d       = 1'b1;
          mode_mask_d = 4'hF;
          freq_mask_d = 4'hF;
          streak_d    = '0;
        end else if (step_s && (!mvec_s[mode_q] || !fvec_s[freq_q])) begin
          state_d     = S_ARM;
          err_d       = 1'b1;
          mode_mask_d = 4'hF;
          freq_mask_d = 4'hF;
          streak_d    = '0;
        end else begin
          state_d = S_LOCKED;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mode_mask_d = 4'hF;
        freq_mask_d = 4'hF;
        streak_d    = '0;
      end
    endcase
  end

  // Outputs are straight register decodes.
  always_comb begin
    mode_out = mode_q;
    freq_out = freq_q;
    locked   = (state_q == S_LOCKED);
    err      = err_q;
  end

`ifdef ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of err pulses, stepping on the same edge as err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
module tb_led_pattern_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led_in;
  logic [1:0] mode_out, freq_out;
  logic       locked, err;
`ifdef ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  led_pattern_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .led_in   (led_in),
    .mode_out (mode_out),
    .freq_out (freq_out),
    .locked   (locked),
    .err      (err)
`ifdef ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_prev, m_since, m_streak, m_mode, m_freq, m_errcnt;
  bit m_armed, m_locked, m_err;
  bit [3:0] m_mmask, m_fmask;

  function automatic int period_of(input int code);
    case (code)
      0: return 1024;
      1: return 256;
      2: return 64;
      default: return 16;
    endcase
  endfunction

  function automatic void classify(input int o, input int n, input int per,
                                   output bit [3:0] mv, output bit [3:0] fv);
    mv[0] = (n == (((o << 1) | (o >> 7)) & 255));
    mv[1] = (n == (((o >> 1) | (o << 7)) & 255));
    mv[2] = (n == ((o + 1) % 256));
    mv[3] = ((n ^ o) == 255);
    for (int k = 0; k < 4; k++) begin
      int d;
      d = per - period_of(k);
      if (d < 0) d = -d;
      fv[k] = (d <= 2);
    end
  endfunction

  function automatic int bit_index(input bit [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction

  task model_reset();
    m_prev = 0; m_since = 0; m_streak = 0; m_mode = 0; m_freq = 0; m_errcnt = 0;
    m_armed = 0; m_locked = 0; m_err = 0; m_mmask = 4'hF; m_fmask = 4'hF;
  endtask

  task model_step(input int v);
    bit [3:0] mv, fv;
    m_err = 0;
    if (v != m_prev) begin
      if (!m_armed) begin
        m_armed = 1; m_mmask = 4'hF; m_fmask = 4'hF; m_streak = 0;
      end else begin
        classify(m_prev, v, m_since + 1, mv, fv);
        if (m_locked) begin
          if (!mv[m_mode] || !fv[m_freq]) begin
            m_err = 1; m_locked = 0; m_mmask = 4'hF; m_fmask = 4'hF; m_streak = 0;
          end
        end else begin
          m_mmask &= mv;
          m_fmask &= fv;
          if (m_mmask == 0 || m_fmask == 0) begin
            m_mmask = 4'hF; m_fmask = 4'hF; m_streak = 0;
          end else begin
            m_streak++;
            if (m_streak >= 4 && $countones(m_mmask) == 1 && $countones(m_fmask) == 1) begin
              m_locked = 1; m_mode = bit_index(m_mmask); m_freq = bit_index(m_fmask);
            end
          end
        end
      end
      m_since = 0;
    end else begin
      // no step for longer than the slowest period plus tolerance
      if (m_armed && m_since + 1 > 1024 + 2) begin
        if (m_locked) m_err = 1;
        m_locked = 0; m_armed = 0; m_mmask = 4'hF; m_fmask = 4'hF; m_streak = 0;
      end
      if (m_since < 4095) m_since++;
    end
    if (m_err && m_errcnt < 255) m_errcnt++;
    m_prev = v;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step(int'(led_in));
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("mode_out", int'(mode_out), m_locked || m_mode != 0 ? m_mode : 0);
      check("freq_out", int'(freq_out), m_freq);
      check("locked", int'(locked), int'(m_locked));
      check("err", int'(err), int'(m_err));
`ifdef ERR_CNT_EN
      check("err_cnt", int'(err_cnt), m_errcnt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] last_v;
  int since, err_seen;
  bit lock_seen;

  task automatic tick(input logic [7:0] v);
    led_in = v;
    @(posedge clk);
    #1;
    if (v != last_v) since = 0; else since++;
    last_v = v;
    err_seen += int'(err);
    if (locked) lock_seen = 1'b1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  function automatic logic [7:0] nxt(input int md, input logic [7:0] v);
    case (md)
      0: return {v[6:0], v[7]};
      1: return {v[0], v[7:1]};
      2: return v + 8'd1;
      default: return ~v;
    endcase
  endfunction

  task automatic run_pat(input int md, input logic [7:0] v0, input int per,
                         input int nvals, output logic [7:0] vlast);
    logic [7:0] v;
    v = v0;
    vlast = v0;
    for (int i = 0; i < nvals; i++) begin
      hold(v, per);
      vlast = v;
      v = nxt(md, v);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    led_in = 8'h00;
    last_v = 8'h00;
    since = 0; err_seen = 0; lock_seen = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] vl;
    bit got;
    reset = 1'b1;
    led_in = 8'h00;
    last_v = 8'h00;
    since = 0; err_seen = 0; lock_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_mode_freq", int'({mode_out, freq_out}), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // rotate-left at 16 clocks: locks on the 5th step
    run_pat(0, 8'h01, 16, 4, vl);
    check("rotl_not_yet_locked", int'(locked), 0);
    tick(8'h10);
    check("rotl_locked", int'(locked), 1);
    check("rotl_mode", int'(mode_out), 0);
    check("rotl_freq", int'(freq_out), 3);
    hold(8'h10, 15);
    check("rotl_no_err", err_seen, 0);

    // bus frozen while locked: stall err 1027 clocks after the last step
    got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      tick(8'h10);
      if (err) got = 1'b1;
    end
    check("stall_err_seen", int'(got), 1);
    check("stall_err_delay", since, 1027);
    check("stall_unlocked", int'(locked), 0);
    tick(8'h10);
    check("stall_err_one_cycle", int'(err), 0);

    // up-count at 64 clocks: 01->02 ambiguity resolves to up-count
    do_reset();
    hold(8'h00, 64);
    run_pat(2, 8'h01, 64, 5, vl);
    check("cnt_locked", int'(locked), 1);
    check("cnt_mode", int'(mode_out), 2);
    check("cnt_freq", int'(freq_out), 2);

    // invert-toggle at 256, then switch to rotate-right
    do_reset();
    run_pat(3, 8'h0F, 256, 6, vl);
    check("inv_locked", int'(locked), 1);
    check("inv_mode", int'(mode_out), 3);
    check("inv_freq", int'(freq_out), 1);
    check("inv_no_err", err_seen, 0);
    tick(8'h78);
    check("switch_err", int'(err), 1);
    check("switch_unlocked", int'(locked), 0);
    hold(8'h78, 255);
    run_pat(1, 8'h3C, 256, 4, vl);
    check("rotr_locked", int'(locked), 1);
    check("rotr_mode", int'(mode_out), 1);
    check("rotr_freq", int'(freq_out), 1);
    check("switch_err_count", err_seen, 1);

    // period 19 never locks; period 18 locks at freq 3
    do_reset();
    run_pat(0, 8'h01, 19, 12, vl);
    check("p19_never_locked", int'(lock_seen), 0);
    check("p19_no_err", err_seen, 0);
    run_pat(0, nxt(0, vl), 18, 5, vl);
    check("p18_locked", int'(locked), 1);
    check("p18_freq", int'(freq_out), 3);

    // reset while locked: outputs clear at once, no err
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_locked", int'(locked), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_mode_freq", int'({mode_out, freq_out}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    led_in = 8'h00;
    last_v = 8'h00;

    // randomized bursts checked by the model
    for (int b = 0; b < 16; b++) begin
      int md, per, ns;
      logic [7:0] v;
      md  = $urandom_range(0, 3);
      per = period_of($urandom_range(1, 3)) + $urandom_range(0, 6) - 3;
      ns  = $urandom_range(3, 7);
      v   = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 3) == 0) hold(8'($urandom_range(0, 255)), per);
      run_pat(md, v, per, ns, vl);
    end
    run_pat(int'($urandom_range(0, 3)), 8'($urandom_range(1, 254)),
            1024 + $urandom_range(0, 4) - 2, 5, vl);
    hold(vl, 1040);

`ifdef ERR_CNT_EN
    do_reset();
    run_pat(0, 8'h01, 16, 5, vl);
    for (int r = 0; r < 300; r++) run_pat(0, ~vl, 16, 5, vl);
    check("errcnt_pulses", err_seen, 300);
    check("errcnt_saturated", int'(err_cnt), 255);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_monitor.md
Name: led_pattern_monitor

Overview:
- Passive checker on the 8-bit LED pattern bus driven by the mode/frequency pattern generator.
- Watches the bus each clock and infers which pattern mode and which step-rate code produced it.
- Asserts lock once the inference is stable, and flags mismatches and stalls.
- Used in self-checking benches and as an on-chip sanity monitor beside the generator.

Parameters:
- P0, 1024: clocks per step for freq code 0 (slowest).
- P1, 256: clocks per step for freq code 1.
- P2, 64: clocks per step for freq code 2.
- P3, 16: clocks per step for freq code 3 (fastest).
- TOL, 2: allowed ± deviation, in clocks, of a measured step period.
- LOCK_N, 4: consecutive consistent steps required to lock.
- CNT_W, 12: period counter width; must hold P0+TOL+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- led_in  in  8  pattern bus from the generator, synchronous to clk.
- mode_out  out  2  inferred mode: 0 rotate-left one-hot, 1 rotate-right one-hot, 2 binary up-count, 3 invert-toggle.
- freq_out  out  2  inferred freq code, 0..3.
- locked  out  1  mode_out and freq_out are valid.
- err  out  1  one-cycle pulse on a mismatch or stall while locked.

Behaviour:
- Reset (async, active-high): all outputs 0; led_q=0, cnt=0, armed=0, mode_mask=4'hF, freq_mask=4'hF, streak=0.
- Each clock: led_q<=led_in. Step event when led_in!=led_q. cnt counts clocks since the last step, saturating at all-ones; on a step, period=cnt+1 and cnt<=0.
- First step after reset or resync: sets armed=1 only. No classification.
- Mode match vector, per armed step (new=led_in, old=led_q):
  - bit0: new==rotl(old,1).
  - bit1: new==rotr(old,1).
  - bit2: new==old+1 mod 256.
  - bit3: (new^old)==8'hFF.
- Several bits may be set for one step (e.g. 01->02 sets bits 0 and 2; 7F->80 sets bits 2 and 3).
- Freq match vector: bit k set when |period-Pk|<=TOL. Comparisons use unsigned CNT_W+1-bit arithmetic.
- Unlocked, per armed step:
  - mode_mask&=mvec; freq_mask&=fvec; streak++.
  - If either mask becomes 0: resync (masks to F, streak=0, armed stays 1; the current step counts as the new arming step).
  - When streak>=LOCK_N and both masks are one-hot: locked<=1; mode_out/freq_out<=index of the set bit. Outputs update the cycle after that step.
  - If streak>=LOCK_N but a mask is not one-hot: keep accumulating.
- Locked, per step: if mvec[mode_out]==0 or fvec[freq_out]==0, then err pulses 1 cycle, locked<=0, resync. mode_out/freq_out hold their last values.
- Stall: while armed, cnt>P0+TOL with no step:
  - If locked: err pulse once, locked<=0, armed<=0, masks reset.
  - If unlocked: silent rearm.
- Static bus (no steps ever): locked stays 0, no err.
- Reset mid-lock: immediate return to reset values; no err.

Optional Feature:
- Macro ERR_CNT_EN.
- Defined: adds output port err_cnt[7:0]. It increments on every err pulse, saturates at 255, and resets to 0.
- Undefined: no port and no counter; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - mode codes MODE_ROTL=0, MODE_ROTR=1, MODE_CNT=2, MODE_INV=3;
  - default period constants P0..P3 and TOL, so the generator and monitor share one source.
- One natural sub-module: led_step_classifier, purely combinational. Inputs old, new, period. Outputs mvec[3:0], fvec[3:0].
- Lock FSM (IDLE/ARM/TRACK/LOCKED) and counters live in the top.

Test Plan:
- Rotate-left from 01 every 16 clocks -> locked=1 after the 5th step, mode_out=0, freq_out=3, no err.
- Up-count from 00 every 64 clocks (01->02 ambiguous with rotl) -> mask resolves; locked with mode_out=2, freq_out=2.
- Locked in 0F/F0 toggle at 256-clock period, then switch to rotate-right at 256 -> one err pulse at the first rotate-right step; relock with mode_out=1 after LOCK_N steps.
- Locked at P3, then bus frozen -> err pulse 1 cycle at cnt=P0+TOL+1 (1027 clocks after the last step); locked=0.
- Step period 19 (outside 16±2) -> never locks, err stays 0; at period 18 -> locks with freq_out=3.
- Assert reset while locked -> all outputs 0 within the same cycle; no err. With ERR_CNT_EN defined, err_cnt equals the number of err pulses and saturates at 255 after 300 forced mismatches.
